// File: rtl/mem_arbiter.sv
// mem_arbiter: connects the IFU and the LSU to one shared memory port.
// It serves one transaction at a time through IDLE -> REQ -> WAIT -> RESP.
// A watchdog aborts a transaction that stays in REQ/WAIT for too long.
module mem_arbiter #(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // The watchdog aborts when the counter holds this value at a clock edge.
  // That gives exactly TIMEOUT_CYCLES cycles in REQ+WAIT.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_owner_lsu;
  logic             r_last_lsu;
  logic [CNT_W-1:0] r_wdog;
  logic             r_mem_req_valid;
  logic             r_mem_resp_ready;
  logic [31:0]      r_mem_addr;
  logic             r_mem_wen;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wmask;
  logic             r_ifu_resp_valid;
  logic [31:0]      r_ifu_rdata;
  logic             r_ifu_resp_err;
  logic             r_lsu_resp_valid;
  logic [31:0]      r_lsu_rdata;
  logic             r_lsu_resp_err;
  logic             r_timeout_err;

  logic             w_grant_ifu;
  logic             w_grant_lsu;
  logic             w_abort;
  logic             w_owner_taken;

  // Pick a master in IDLE. Gating with rst_n keeps both readies low while reset is held.
  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (rst_n && r_state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (ARB_MODE == 1 || !r_last_lsu) begin
          w_grant_lsu = 1'b1;
        end else begin
          w_grant_ifu = 1'b1;
        end
      end else if (lsu_req_valid) begin
        w_grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        w_grant_ifu = 1'b1;
      end
    end
  end

  assign w_abort       = (TIMEOUT_CYCLES != 0) && (r_state == REQ || r_state == WAIT) &&
                         (r_wdog == WDOG_LAST);
  assign w_owner_taken = r_owner_lsu ? lsu_resp_ready : ifu_resp_ready;

  // Transaction sequencer: one transaction at a time, all outputs registered.
  // An abort overrides any memory handshake that arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_owner_lsu      <= 1'b0;
      r_last_lsu       <= 1'b0;
      r_wdog           <= '0;
      r_mem_req_valid  <= 1'b0;
      r_mem_resp_ready <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wen        <= 1'b0;
      r_mem_wdata      <= '0;
      r_mem_wmask      <= '0;
      r_ifu_resp_valid <= 1'b0;
      r_ifu_rdata      <= '0;
      r_ifu_resp_err   <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_lsu_rdata      <= '0;
      r_lsu_resp_err   <= 1'b0;
      r_timeout_err    <= 1'b0;
    end else if (w_abort) begin
      r_mem_req_valid  <= 1'b0;
      r_mem_resp_ready <= 1'b0;
      r_timeout_err    <= 1'b1;
      if (r_owner_lsu) begin
        r_lsu_resp_valid <= 1'b1;
        r_lsu_rdata      <= '0;
        r_lsu_resp_err   <= 1'b1;
      end else begin
        r_ifu_resp_valid <= 1'b1;
        r_ifu_rdata      <= '0;
        r_ifu_resp_err   <= 1'b1;
      end
      r_state <= RESP;
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_resp_ready <= 1'b1;
          if (w_grant_ifu || w_grant_lsu) begin
            r_owner_lsu      <= w_grant_lsu;
            r_last_lsu       <= w_grant_lsu;
            r_mem_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_mem_wen        <= w_grant_lsu & lsu_wen;
            r_mem_wdata      <= w_grant_lsu ? lsu_wdata : 32'h0;
            r_mem_wmask      <= w_grant_lsu ? lsu_wmask : 4'h0;
            r_mem_req_valid  <= 1'b1;
            r_mem_resp_ready <= 1'b0;
            r_wdog           <= '0;
            r_state          <= REQ;
          end
        end
        REQ: begin
          r_wdog <= r_wdog + 1'b1;
          if (mem_req_ready) begin
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b1;
            r_state          <= WAIT;
          end
        end
        WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (mem_resp_valid) begin
            r_mem_resp_ready <= 1'b0;
            if (r_owner_lsu) begin
              r_lsu_resp_valid <= 1'b1;
              r_lsu_rdata      <= mem_rdata;
              r_lsu_resp_err   <= mem_resp_err;
            end else begin
              r_ifu_resp_valid <= 1'b1;
              r_ifu_rdata      <= mem_rdata;
              r_ifu_resp_err   <= mem_resp_err;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          if (w_owner_taken) begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_mem_resp_ready <= 1'b1;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = w_grant_ifu;
  assign lsu_req_ready  = w_grant_lsu;
  assign ifu_resp_valid = r_ifu_resp_valid;
  assign ifu_rdata      = r_ifu_rdata;
  assign ifu_resp_err   = r_ifu_resp_err;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign lsu_rdata      = r_lsu_rdata;
  assign lsu_resp_err   = r_lsu_resp_err;
  assign mem_req_valid  = r_mem_req_valid;
  assign mem_addr       = r_mem_addr;
  assign mem_wen        = r_mem_wen;
  assign mem_wdata      = r_mem_wdata;
  assign mem_wmask      = r_mem_wmask;
  assign mem_resp_ready = r_mem_resp_ready;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transactions against a transaction-level model.
// The model covers round-robin grant, pass-through of request fields and
// response data, watchdog abort, stale-response drop and async reset.
module tb_mem_arbiter;
  localparam int TIMEOUT = 12;

  logic        clk, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit modelLastLsu = 1'b0;

  mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .timeout_err(timeout_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the design never returns control
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkReqFields(input string tag, input logic [31:0] eAddr, input logic eWen,
                                input logic [31:0] eWdata, input logic [3:0] eWmask);
    checkOutput({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    checkOutput({tag, "_addr"}, mem_addr, eAddr);
    checkOutput({tag, "_wen"}, 32'(mem_wen), 32'(eWen));
    checkOutput({tag, "_wdata"}, mem_wdata, eWdata);
    checkOutput({tag, "_wmask"}, 32'(mem_wmask), 32'(eWmask));
    checkOutput({tag, "_resp_ready"}, 32'(mem_resp_ready), 32'd0);
  endtask

  // One complete transaction, called at a negedge while the DUT is idle
  task automatic applyStimulus(input bit ifuV, input bit lsuV, input logic [31:0] iAddr,
                               input logic [31:0] lAddr, input bit wen, input logic [31:0] wdata,
                               input logic [3:0] wmask, input int reqDly, input int respDly,
                               input int bpDly, input logic [31:0] rdata, input bit err);
    bit          grantLsu;
    logic [31:0] eAddr, eWdata;
    logic        eWen;
    logic [3:0]  eWmask;
    if (ifuV && lsuV) grantLsu = !modelLastLsu;
    else              grantLsu = lsuV;
    eAddr  = grantLsu ? lAddr : iAddr;
    eWen   = grantLsu & wen;
    eWdata = grantLsu ? wdata : 32'h0;
    eWmask = grantLsu ? wmask : 4'h0;

    ifu_req_valid = ifuV; ifu_addr = iAddr;
    lsu_req_valid = lsuV; lsu_addr = lAddr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
    #1;
    checkOutput("grant_ifu", 32'(ifu_req_ready), 32'(!grantLsu));
    checkOutput("grant_lsu", 32'(lsu_req_ready), 32'(grantLsu));
    modelLastLsu = grantLsu;
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
    lsu_wen = ~lsu_wen;

    for (int c = 0; c < reqDly; c++) begin
      mem_req_ready = 1'b0;
      #1 checkReqFields("stall", eAddr, eWen, eWdata, eWmask);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1 checkReqFields("issue", eAddr, eWen, eWdata, eWmask);
    @(negedge clk);
    mem_req_ready = 1'b0;

    for (int c = 0; c < respDly; c++) begin
      #1;
      checkOutput("wait_req_valid", 32'(mem_req_valid), 32'd0);
      checkOutput("wait_resp_ready", 32'(mem_resp_ready), 32'd1);
      checkOutput("wait_no_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = err;
    #1 checkOutput("latch_resp_ready", 32'(mem_resp_ready), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = $urandom; mem_resp_err = 1'b0;

    for (int c = 0; c <= bpDly; c++) begin
      if (c == bpDly) begin
        if (grantLsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
      end
      if (grantLsu) ifu_req_valid = 1'b1; else lsu_req_valid = 1'b1;
      #1;
      checkOutput("resp_valid", 32'(grantLsu ? lsu_resp_valid : ifu_resp_valid), 32'd1);
      checkOutput("resp_rdata", grantLsu ? lsu_rdata : ifu_rdata, rdata);
      checkOutput("resp_err", 32'(grantLsu ? lsu_resp_err : ifu_resp_err), 32'(err));
      checkOutput("other_resp_valid", 32'(grantLsu ? ifu_resp_valid : lsu_resp_valid), 32'd0);
      checkOutput("other_req_ready", 32'(grantLsu ? ifu_req_ready : lsu_req_ready), 32'd0);
      @(negedge clk);
    end
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1 checkOutput("idle_resp_valid", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
  endtask

  // Main sequence: reset, directed cases, random traffic, timeout, reset in WAIT
  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_resp_valids", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IFU fetch, minimum latency
    applyStimulus(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0413, 0);
    // Simultaneous requests alternate LSU, IFU, LSU, IFU
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, $urandom, $urandom, 0, $urandom, 4'hF, 0, 1, 0, $urandom, 0);
    // Store held stable through 5 stalled cycles
    applyStimulus(0, 1, 32'h0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'b0011, 5, 1, 1,
                  32'h1234_5678, 0);
    // Response backpressure with a competing LSU request
    applyStimulus(1, 0, 32'h8000_0004, 32'h0, 0, 32'h0, 4'h0, 1, 0, 4, 32'h0010_0093, 1);

    for (int i = 0; i < 40; i++) begin
      int v;
      v = $urandom_range(1, 3);
      applyStimulus(v[0], v[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, 1'($urandom));
    end

    // Watchdog: memory never accepts, abort wins over a late handshake
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    #1 checkOutput("to_grant", 32'(ifu_req_ready), 32'd1);
    modelLastLsu = 1'b0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      #1 checkOutput("to_req_valid", 32'(mem_req_valid), 32'd1);
      @(negedge clk);
    end
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b0;
    #1;
    checkOutput("to_last_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("to_flag_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    checkOutput("to_resp_valid", 32'(ifu_resp_valid), 32'd1);
    checkOutput("to_rdata", ifu_rdata, 32'd0);
    checkOutput("to_err", 32'(ifu_resp_err), 32'd1);
    checkOutput("to_flag", 32'(timeout_err), 32'd1);
    checkOutput("to_req_dropped", 32'(mem_req_valid), 32'd0);
    checkOutput("to_lsu_quiet", 32'(lsu_resp_valid), 32'd0);
    @(negedge clk);
    ifu_resp_ready = 1'b1;
    #1 checkOutput("to_resp_hold", 32'(ifu_resp_valid), 32'd1);
    @(negedge clk);
    ifu_resp_ready = 1'b0;

    // Stray response arriving in IDLE is discarded
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b1;
    #1 checkOutput("stale_resp_ready", 32'(mem_resp_ready), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("stale_no_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      checkOutput("stale_rdata", ifu_rdata, 32'd0);
      checkOutput("sticky_flag", 32'(timeout_err), 32'd1);
      @(negedge clk);
    end
    applyStimulus(0, 1, 0, $urandom, 0, 0, 4'h0, 0, 0, 0, $urandom, 0);
    checkOutput("sticky_after_txn", 32'(timeout_err), 32'd1);

    // Async reset while waiting for the memory response
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b1;
    lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'hF;
    #1 checkOutput("rw_grant", 32'(lsu_req_ready), 32'd1);
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 checkOutput("rw_in_wait", 32'(mem_resp_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_resp_ready", 32'(mem_resp_ready), 32'd0);
    checkOutput("rw_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rw_addr", mem_addr, 32'd0);
    checkOutput("rw_wdata", mem_wdata, 32'd0);
    checkOutput("rw_wen_wmask", 32'({mem_wen, mem_wmask}), 32'd0);
    checkOutput("rw_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rw_resp_valids", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
    modelLastLsu = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput("rw_dropped", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      @(negedge clk);
    end
    applyStimulus(1, 1, $urandom, $urandom, 0, $urandom, 4'h1, 1, 1, 1, $urandom, 0);
    applyStimulus(1, 1, $urandom, $urandom, 1, $urandom, 4'h8, 0, 2, 0, $urandom, 1);
    checkOutput("post_rst_flag", 32'(timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter and sequencer for the core's single data/instruction memory port.
- Masters: IFU (fetch, read-only) and LSU (load/store). It drives the shared memory interface one transaction at a time.
- The request/response valid-ready handshakes on each side are decoupled.
- A watchdog aborts transactions that hang.

Parameters:
- ARB_MODE, 0: 0 = round-robin on simultaneous requests; 1 = fixed LSU priority.
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before abort; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  fetch response available
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  32  fetched instruction
- ifu_resp_err  out  1  fetch error/timeout
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte enables
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  32  load data
- lsu_resp_err  out  1  access error/timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr / mem_wen / mem_wdata / mem_wmask  out  32/1/32/4  latched request fields
- mem_resp_valid  in  1  memory response
- mem_resp_ready  out  1  arbiter accepts response
- mem_rdata  in  32  response data
- mem_resp_err  in  1  response error
- timeout_err  out  1  sticky: a watchdog abort has occurred

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; every valid/ready output = 0; all data/addr/mask outputs = 0.
  - timeout_err = 0; last_grant = IFU; watchdog = 0.
  - Reset mid-transaction drops the transaction and produces no response.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Arbitrate.
    - Only one valid: grant it.
    - Both valid, ARB_MODE=1: grant LSU.
    - Both valid, ARB_MODE=0: grant the master that is not last_grant.
  - Granted master's req_ready = 1 combinationally in the same cycle, and only it.
  - Latch addr/wen/wdata/wmask into the mem_* registers. For IFU: wen=0, wmask=0, wdata=0.
  - Record owner; update last_grant; go to REQ.
  - mem_resp_ready = 1. Any mem_resp_valid seen here is a stale post-abort response and is discarded.
- REQ:
  - mem_req_valid = 1; mem_* fields stable.
  - On mem_req_ready: go to WAIT.
- WAIT:
  - mem_resp_ready = 1.
  - On mem_resp_valid: latch mem_rdata and mem_resp_err into the owner's rdata/resp_err; go to RESP.
- RESP:
  - Owner's resp_valid = 1; rdata/err held until that master's resp_ready = 1, then go to IDLE.
  - The non-owner's resp_valid stays 0.
  - No new request is accepted until the cycle after returning to IDLE.
- Minimum latency: accept in cycle N; mem request in N+1; response can be latched at the end of N+2; resp_valid in N+3.
- Watchdog:
  - Counter clears on entering REQ and increments every cycle in REQ or WAIT.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to RESP with owner rdata = 0, resp_err = 1, timeout_err set to 1.
  - timeout_err stays set until reset.
  - mem_req_valid drops on the abort cycle. A simultaneous mem_req_ready/mem_resp_valid on the abort cycle is ignored (abort wins).
- Data outputs to a master change only on entry to RESP.
- The master-side request inputs are not sampled outside IDLE. A master that deasserts req_valid before being granted is never granted.

Test Plan:
- IFU only: ifu_addr=0x8000_0000; mem_req_ready=1; mem_resp 1 cycle later with rdata=0x0000_0413 -> ifu_req_ready pulses once; mem_addr=0x8000_0000, mem_wen=0; ifu_resp_valid 3 cycles after accept with rdata=0x0000_0413, err=0.
- Simultaneous requests, ARB_MODE=0, after reset -> LSU granted first, then IFU. Repeat both valid back-to-back -> grants alternate LSU, IFU, LSU, IFU.
- LSU store: addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=4'b0011 -> mem_wen=1 and mem_wmask=4'b0011 held stable while mem_req_ready=0 for 5 cycles; then a single response to the LSU only.
- Backpressure: response latched; ifu_resp_ready=0 for 4 cycles -> ifu_resp_valid and rdata held constant; lsu_req_valid=1 meanwhile yields lsu_req_ready=0 until the cycle after IDLE is re-entered.
- Timeout: TIMEOUT_CYCLES=4, mem_req_ready=0 forever -> abort after 4 cycles in REQ; resp_err=1, rdata=0, timeout_err=1 and stays 1. A later stray mem_resp_valid in IDLE is dropped with no resp_valid.
- Async reset asserted in WAIT -> all outputs 0 immediately, without waiting for a clock edge; after release the next request is served normally with timeout_err=0.
